// File: rtl/bcd_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter.
// Contents:
//   bcd_state_t  - FSM state encoding (IDLE, SHIFT, DONE)
//   BCD_DIGIT_W  - bits per packed BCD digit
//   MAX_DIGITS   - largest digit count the all-nines helper can produce
//   all_nines()  - packed pattern with the low n digits set to 9
package bcd_pkg;

    localparam int BCD_DIGIT_W = 4;
    localparam int MAX_DIGITS  = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } bcd_state_t;

    // Saturation value; callers slice off the low n digits they need.
    function automatic logic [BCD_DIGIT_W*MAX_DIGITS-1:0] all_nines(input int n);
        logic [BCD_DIGIT_W*MAX_DIGITS-1:0] r;
        r = '0;
        for (int i = 0; i < MAX_DIGITS; i++) begin
            if (i < n) r[BCD_DIGIT_W*i +: BCD_DIGIT_W] = 4'd9;
        end
        return r;
    endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble digit correction: a digit of 5 or more gets +3 so that the
// following left shift carries into the next decimal digit.
// Ports:
//   i_digit - scratch BCD digit before the shift
//   o_digit - corrected digit (4-bit wrap, no carry out)
module bcd_digit_adj
    import bcd_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] i_digit,
    output logic [BCD_DIGIT_W-1:0] o_digit
);

    assign o_digit = (i_digit >= 4'd5) ? i_digit + 4'd3 : i_digit;

endmodule

// File: rtl/bcd_dabble.sv
// Sequential binary-to-BCD converter (shift-and-add-3), one bit per cycle.
// Saturates to all nines on overflow and flags leading-zero digits for the
// seven-segment blanking logic.
// Ports:
//   clk    - clock, rising edge
//   reset  - synchronous, active high; aborts any conversion
//   start  - conversion request, honoured only when idle
//   bin    - WIDTH-bit unsigned value, captured with an accepted start
//   busy   - high while shifting
//   done   - one-cycle pulse, coincides with new bcd/ovf/blank
//   bcd    - packed BCD result, digit 0 in bits [3:0]
//   ovf    - last conversion saturated (bin >= 10**DIGITS)
//   blank  - bit i set when digit i is a leading zero (bit 0 always 0)
module bcd_dabble
    import bcd_pkg::*;
#(
    parameter int WIDTH  = 6,
    parameter int DIGITS = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic [WIDTH-1:0]              bin,
    output logic                          busy,
    output logic                          done,
    output logic [BCD_DIGIT_W*DIGITS-1:0] bcd,
    output logic                          ovf,
    output logic [DIGITS-1:0]             blank
);

    localparam int SW = BCD_DIGIT_W * DIGITS;
    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [BCD_DIGIT_W*MAX_DIGITS-1:0] NINES_ALL = all_nines(DIGITS);
    localparam logic [SW-1:0]                     NINES     = NINES_ALL[SW-1:0];
    // Reset shows a single "0": every digit but the ones digit blanked.
    localparam logic [DIGITS-1:0]                 BLANK_RST = ~DIGITS'(1);

    bcd_state_t        r_state;
    logic [CW-1:0]     r_cnt;
    logic [WIDTH-1:0]  r_shift;
    logic [SW-1:0]     r_scratch;
    logic              r_ovf_sticky;
    logic              r_busy;
    logic              r_done;
    logic [SW-1:0]     r_bcd;
    logic              r_ovf;
    logic [DIGITS-1:0] r_blank;

    logic [SW-1:0]     w_adj;
    logic [SW-1:0]     w_scr_next;
    logic [WIDTH-1:0]  w_shift_next;
    logic              w_ovf_next;
    logic [DIGITS-1:0] w_blank_next;

    genvar g;
    generate
        for (g = 0; g < DIGITS; g++) begin : g_adj
            bcd_digit_adj u_adj (
                .i_digit (r_scratch[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
                .o_digit (w_adj[g*BCD_DIGIT_W +: BCD_DIGIT_W])
            );
        end
    endgenerate

    assign w_scr_next   = {w_adj[SW-2:0], r_shift[WIDTH-1]};
    assign w_shift_next = r_shift << 1;
    // A bit leaving the top digit means the running prefix already reached
    // 10**DIGITS; the prefix only grows, so the flag stays valid once set.
    assign w_ovf_next   = r_ovf_sticky | w_adj[SW-1];

    // Leading-zero run scanned from the most significant digit downward.
    always_comb begin
        logic v_zero;
        w_blank_next = '0;
        v_zero       = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            v_zero          = v_zero & (w_scr_next[i*BCD_DIGIT_W +: BCD_DIGIT_W] == 4'd0);
            w_blank_next[i] = v_zero;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_shift      <= '0;
            r_scratch    <= '0;
            r_ovf_sticky <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_bcd        <= '0;
            r_ovf        <= 1'b0;
            r_blank      <= BLANK_RST;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_shift      <= bin;
                        r_scratch    <= '0;
                        r_ovf_sticky <= 1'b0;
                        r_cnt        <= CW'(WIDTH);
                        r_busy       <= 1'b1;
                        r_state      <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    r_scratch    <= w_scr_next;
                    r_shift      <= w_shift_next;
                    r_ovf_sticky <= w_ovf_next;
                    r_cnt        <= r_cnt - CW'(1);
                    if (r_cnt == CW'(1)) begin
                        // Results are loaded from the final iteration's next
                        // value so they are visible during the DONE cycle,
                        // alongside the done pulse.
                        r_state <= ST_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        if (w_ovf_next) begin
                            r_bcd   <= NINES;
                            r_ovf   <= 1'b1;
                            r_blank <= '0;
                        end else begin
                            r_bcd   <= w_scr_next;
                            r_ovf   <= 1'b0;
                            r_blank <= w_blank_next;
                        end
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy  = r_busy;
    assign done  = r_done;
    assign bcd   = r_bcd;
    assign ovf   = r_ovf;
    assign blank = r_blank;

endmodule

// File: tb/tb_bcd_dabble.sv
module tb_bcd_dabble;

    logic       clk   = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [9:0] bin   = '0;
    logic       chk_en = 1'b0;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    // Four configurations share the stimulus; each sees the low bits of bin.
    logic       busy_a, done_a, ovf_a;  logic [7:0]  bcd_a;  logic [1:0] blank_a;
    logic       busy_b, done_b, ovf_b;  logic [7:0]  bcd_b;  logic [1:0] blank_b;
    logic       busy_c, done_c, ovf_c;  logic [11:0] bcd_c;  logic [2:0] blank_c;
    logic       busy_d, done_d, ovf_d;  logic [11:0] bcd_d;  logic [2:0] blank_d;

    bcd_dabble #(.WIDTH(6), .DIGITS(2)) u_a (
        .clk(clk), .reset(reset), .start(start), .bin(bin[5:0]),
        .busy(busy_a), .done(done_a), .bcd(bcd_a), .ovf(ovf_a), .blank(blank_a));
    bcd_dabble #(.WIDTH(8), .DIGITS(2)) u_b (
        .clk(clk), .reset(reset), .start(start), .bin(bin[7:0]),
        .busy(busy_b), .done(done_b), .bcd(bcd_b), .ovf(ovf_b), .blank(blank_b));
    bcd_dabble #(.WIDTH(8), .DIGITS(3)) u_c (
        .clk(clk), .reset(reset), .start(start), .bin(bin[7:0]),
        .busy(busy_c), .done(done_c), .bcd(bcd_c), .ovf(ovf_c), .blank(blank_c));
    bcd_dabble #(.WIDTH(10), .DIGITS(3)) u_d (
        .clk(clk), .reset(reset), .start(start), .bin(bin),
        .busy(busy_d), .done(done_d), .bcd(bcd_d), .ovf(ovf_d), .blank(blank_d));

    logic [11:0] d_bcd   [4];
    logic [2:0]  d_blank [4];
    logic        d_busy  [4];
    logic        d_done  [4];
    logic        d_ovf   [4];

    assign d_bcd[0] = {4'h0, bcd_a};  assign d_blank[0] = {1'b0, blank_a};
    assign d_bcd[1] = {4'h0, bcd_b};  assign d_blank[1] = {1'b0, blank_b};
    assign d_bcd[2] = bcd_c;          assign d_blank[2] = blank_c;
    assign d_bcd[3] = bcd_d;          assign d_blank[3] = blank_d;
    assign d_busy[0] = busy_a; assign d_done[0] = done_a; assign d_ovf[0] = ovf_a;
    assign d_busy[1] = busy_b; assign d_done[1] = done_b; assign d_ovf[1] = ovf_b;
    assign d_busy[2] = busy_c; assign d_done[2] = done_c; assign d_ovf[2] = ovf_c;
    assign d_busy[3] = busy_d; assign d_done[3] = done_d; assign d_ovf[3] = ovf_d;

    // ---------------- reference model ----------------
    int mW [4] = '{6, 8, 8, 10};
    int mD [4] = '{2, 2, 3, 3};
    int ph [4];          // cycles since accepted start; 0 = idle
    int val[4];
    logic [11:0] e_bcd  [4];
    logic [2:0]  e_blank[4];
    logic        e_ovf  [4];

    // Decimal conversion by division, with saturation and leading-zero flags.
    function automatic void conv(input int v, input int d,
                                 output logic [11:0] b, output logic o,
                                 output logic [2:0] bl);
        int t;
        b  = '0;
        bl = '0;
        o  = 1'b0;
        if (v >= 10**d) begin
            o = 1'b1;
            for (int i = 0; i < d; i++) b[4*i +: 4] = 4'd9;
        end else begin
            t = v;
            for (int i = 0; i < d; i++) begin
                b[4*i +: 4] = 4'(t % 10);
                t = t / 10;
                if (i >= 1 && v < 10**i) bl[i] = 1'b1;
            end
        end
    endfunction

    initial begin
        for (int k = 0; k < 4; k++) begin
            ph[k] = 0; val[k] = 0; e_bcd[k] = '0; e_blank[k] = '0; e_ovf[k] = 1'b0;
        end
        forever begin
            @(posedge clk);
            for (int k = 0; k < 4; k++) begin
                if (reset) begin
                    ph[k] = 0;
                    conv(0, mD[k], e_bcd[k], e_ovf[k], e_blank[k]);
                end else if (ph[k] == 0) begin
                    if (start) begin
                        val[k] = int'(bin) & ((1 << mW[k]) - 1);
                        ph[k]  = 1;
                    end
                end else if (ph[k] == mW[k] + 1) begin
                    ph[k] = 0;
                end else begin
                    ph[k] = ph[k] + 1;
                    if (ph[k] == mW[k] + 1)
                        conv(val[k], mD[k], e_bcd[k], e_ovf[k], e_blank[k]);
                end
            end
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Every-cycle comparison of all instances against the model.
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                for (int k = 0; k < 4; k++) begin
                    check($sformatf("busy%0d", k), 32'(d_busy[k]),
                          32'(ph[k] >= 1 && ph[k] <= mW[k]));
                    check($sformatf("done%0d", k), 32'(d_done[k]), 32'(ph[k] == mW[k] + 1));
                    check($sformatf("bcd%0d", k), 32'(d_bcd[k]), 32'(e_bcd[k]));
                    check($sformatf("ovf%0d", k), 32'(d_ovf[k]), 32'(e_ovf[k]));
                    check($sformatf("blank%0d", k), 32'(d_blank[k]), 32'(e_blank[k]));
                end
            end
        end
    end

    // Start one conversion and wait until the slowest instance is idle again.
    task automatic run(input int v);
        @(negedge clk);
        start = 1'b1;
        bin   = 10'(v);
        @(negedge clk);
        start = 1'b0;
        repeat (11) @(negedge clk);
    endtask

    int perm[1024];
    int ndone;

    initial begin
        reset = 1'b1;
        @(negedge clk);
        chk_en = 1'b1;
        @(negedge clk);
        check("rst_bcd_a",   32'(bcd_a), 32'h0);
        check("rst_blank_a", 32'(blank_a), 32'b10);
        check("rst_blank_c", 32'(blank_c), 32'b110);
        check("rst_busy_a",  32'(busy_a), 32'd0);
        reset = 1'b0;

        // Timing of a full-scale 6-bit conversion.
        @(negedge clk);
        start = 1'b1; bin = 10'd63;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            start = 1'b0;
            check($sformatf("t63_busy_c%0d", c), 32'(busy_a), 32'(c >= 1 && c <= 6));
            check($sformatf("t63_done_c%0d", c), 32'(done_a), 32'(c == 7));
        end
        repeat (4) @(negedge clk);
        check("v63_bcd_a",   32'(bcd_a), 32'h63);
        check("v63_ovf_a",   32'(ovf_a), 32'd0);
        check("v63_blank_a", 32'(blank_a), 32'b00);
        check("v63_blank_d", 32'(blank_d), 32'b100);

        run(0);   check("v0_bcd_a", 32'(bcd_a), 32'h00);  check("v0_blank_a", 32'(blank_a), 32'b10);
        run(9);   check("v9_bcd_a", 32'(bcd_a), 32'h09);  check("v9_blank_a", 32'(blank_a), 32'b10);
        run(40);  check("v40_bcd_a", 32'(bcd_a), 32'h40); check("v40_blank_a", 32'(blank_a), 32'b00);
        run(99);  check("v99_bcd_b", 32'(bcd_b), 32'h99); check("v99_ovf_b", 32'(ovf_b), 32'd0);
        run(100);
        check("v100_bcd_b", 32'(bcd_b), 32'h99); check("v100_ovf_b", 32'(ovf_b), 32'd1);
        check("v100_blank_b", 32'(blank_b), 32'b00); check("v100_bcd_c", 32'(bcd_c), 32'h100);
        run(255);
        check("v255_bcd_b", 32'(bcd_b), 32'h99); check("v255_ovf_b", 32'(ovf_b), 32'd1);
        check("v255_bcd_c", 32'(bcd_c), 32'h255); check("v255_ovf_c", 32'(ovf_c), 32'd0);

        // start while busy and in the done cycle is ignored.
        @(negedge clk);
        start = 1'b1; bin = 10'd45;
        ndone = 0;
        for (int c = 1; c <= 14; c++) begin
            @(negedge clk);
            if (done_a) ndone++;
            if (c == 7) check("ign_bcd_at7", 32'(bcd_a), 32'h45);
            start = (c == 3 || c == 7);
            bin   = (c == 3 || c == 7) ? 10'd12 : 10'd45;
        end
        check("ign_done_count", 32'(ndone), 32'd1);
        check("ign_bcd_a", 32'(bcd_a), 32'h45);

        // Reset mid-conversion aborts it; a new start then completes.
        @(negedge clk);
        start = 1'b1; bin = 10'd45;
        ndone = 0;
        for (int c = 1; c <= 14; c++) begin
            @(negedge clk);
            if (done_a) ndone++;
            if (c == 4) begin
                check("abort_bcd_c4", 32'(bcd_a), 32'h0);
                check("abort_blank_c4", 32'(blank_a), 32'b10);
            end
            if (c == 12) begin
                check("abort_done_c12", 32'(done_a), 32'd1);
                check("abort_bcd_c12", 32'(bcd_a), 32'h17);
            end
            reset = (c == 3);
            start = (c == 5);
            bin   = (c == 5) ? 10'd17 : 10'd45;
        end
        check("abort_done_count", 32'(ndone), 32'd1);

        // reset together with start: the start is lost.
        @(negedge clk);
        reset = 1'b1; start = 1'b1; bin = 10'd33;
        @(negedge clk);
        reset = 1'b0; start = 1'b0;
        @(negedge clk);
        check("rststart_busy_a", 32'(busy_a), 32'd0);

        // Continuous start: every instance restarts at its earliest slot.
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            start = 1'b1;
            bin   = 10'($urandom_range(1023));
        end
        @(negedge clk);
        start = 1'b0;
        repeat (13) @(negedge clk);

        // Every input value, shuffled.
        for (int i = 0; i < 1024; i++) perm[i] = i;
        for (int i = 1023; i > 0; i--) begin
            int j, t;
            j = $urandom_range(i);
            t = perm[i]; perm[i] = perm[j]; perm[j] = t;
        end
        for (int i = 0; i < 1024; i++) run(perm[i]);

        run(1023);
        check("v1023_bcd_d", 32'(bcd_d), 32'h999);
        check("v1023_ovf_d", 32'(ovf_d), 32'd1);
        run(999);
        check("v999_bcd_d", 32'(bcd_d), 32'h999);
        check("v999_ovf_d", 32'(ovf_d), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
